// File: rtl/char_term_16x16.sv
// Writable 16x16 character buffer with a terminal-style byte write port and a ROM-compatible read port.
// Optional macro CHAR_TERM_SCROLL_EN: end-of-screen scrolls up one row instead of wrapping to the top.
module char_term_16x16 #(
   parameter logic [6:0] FILL_CHAR = 7'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code,
   output logic [7:0] cursor_xy,
   output logic       busy
);

   localparam logic [1:0] ST_CLEAR   = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_ROW_CLR = 2'd2;
   localparam logic [1:0] ST_SCROLL  = 2'd3;

   logic [1:0] state_r;
   logic [1:0] state_s;
   logic [7:0] sweep_r;
   logic [7:0] sweep_s;
   logic [7:0] cursor_r;
   logic [7:0] cursor_s;
   logic       ready_r;
   logic [6:0] char_code_r;
   logic       we_s;
   logic [7:0] waddr_s;
   logic [6:0] wdata_s;
   logic       eos_s;
   logic [3:0] row_s;
   logic [3:0] col_s;

   // Cells carry no reset; a reset or FF triggers a fill sweep instead.
   logic [6:0] mem_r [0:255];

   assign row_s     = cursor_r[7:4];
   assign col_s     = cursor_r[3:0];
   assign in_ready  = ready_r;
   assign busy      = ~ready_r;
   assign cursor_xy = cursor_r;
   assign char_code = char_code_r;

   // Next-state, cursor and write-port decode
   always_comb begin
      state_s  = state_r;
      sweep_s  = sweep_r;
      cursor_s = cursor_r;
      we_s     = 1'b0;
      waddr_s  = sweep_r;
      wdata_s  = FILL_CHAR;
      eos_s    = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            we_s = 1'b1;
            if (sweep_r == 8'hFF) begin
               state_s = ST_IDLE;
               sweep_s = 8'h00;
            end else begin
               sweep_s = sweep_r + 8'd1;
            end
         end
         ST_ROW_CLR: begin
            we_s = 1'b1;
            if (sweep_r[3:0] == 4'hF) begin
               state_s = ST_IDLE;
               sweep_s = 8'h00;
            end else begin
               sweep_s = sweep_r + 8'd1;
            end
         end
`ifdef CHAR_TERM_SCROLL_EN
         ST_SCROLL: begin
            // Copy the cell one row below into the current cell, then blank the last row.
            we_s    = 1'b1;
            wdata_s = mem_r[sweep_r + 8'd16];
            if (sweep_r == 8'hEF) begin
               state_s = ST_ROW_CLR;
               sweep_s = 8'hF0;
            end else begin
               sweep_s = sweep_r + 8'd1;
            end
         end
`endif
         ST_IDLE: begin
            if (in_valid) begin
               if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
                  we_s    = 1'b1;
                  waddr_s = cursor_r;
                  wdata_s = in_data[6:0];
                  if (col_s != 4'hF) begin
                     cursor_s = {row_s, col_s + 4'd1};
                  end else if (row_s != 4'hF) begin
                     cursor_s = {row_s + 4'd1, 4'h0};
                  end else begin
                     eos_s = 1'b1;
                  end
               end else begin
                  case (in_data)
                     8'h0D: cursor_s = {row_s, 4'h0};
                     8'h0A: begin
                        if (row_s != 4'hF) begin
                           cursor_s = {row_s + 4'd1, 4'h0};
                        end else begin
                           eos_s = 1'b1;
                        end
                     end
                     8'h08: begin
                        if (col_s != 4'h0) begin
                           cursor_s = {row_s, col_s - 4'd1};
                           we_s     = 1'b1;
                           waddr_s  = {row_s, col_s - 4'd1};
                        end else begin
                           cursor_s = cursor_r;
                        end
                     end
                     8'h0C: begin
                        cursor_s = 8'h00;
                        state_s  = ST_CLEAR;
                        sweep_s  = 8'h00;
                     end
                     default: cursor_s = cursor_r;
                  endcase
               end
            end else begin
               cursor_s = cursor_r;
            end
            if (eos_s) begin
`ifdef CHAR_TERM_SCROLL_EN
               cursor_s = 8'hF0;
               state_s  = ST_SCROLL;
               sweep_s  = 8'h00;
`else
               cursor_s = 8'h00;
               state_s  = ST_ROW_CLR;
               sweep_s  = 8'h00;
`endif
            end else begin
               sweep_s = sweep_r;
            end
         end
         default: begin
            state_s = ST_CLEAR;
            sweep_s = 8'h00;
         end
      endcase
   end

   // Control registers; reset restarts the full fill sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_CLEAR;
         sweep_r  <= 8'h00;
         cursor_r <= 8'h00;
         ready_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         sweep_r  <= sweep_s;
         cursor_r <= cursor_s;
         ready_r  <= (state_s == ST_IDLE);
      end
   end

   // Cell array write port
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[waddr_s] <= wdata_s;
      end
   end

   // Registered read port; a same-cycle write to the addressed cell returns the old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_code_r <= 7'h00;
      end else begin
         char_code_r <= mem_r[char_xy];
      end
   end

endmodule

// File: tb/tb_char_term_16x16.sv
// Self-checking bench for char_term_16x16: cycle model of cells/cursor/busy plus directed literal checks.
`timescale 1ns/1ps
module tb_char_term_16x16;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] char_xy;
   logic [6:0] char_code;
   logic [7:0] cursor_xy;
   logic       busy;

   int n_chk;
   int n_err;

   char_term_16x16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .char_xy   (char_xy),
      .char_code (char_code),
      .cursor_xy (cursor_xy),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: cell array, cursor, and remaining busy cycles of the current bulk operation.
   int mm [256];
   int m_cur;
   int m_busy;
   int m_op;      // 1 full clear, 2 row clear, 3 scroll+clear last row
   int m_step;
   int m_exp;
   bit m_live;

   task automatic m_eos();
`ifdef CHAR_TERM_SCROLL_EN
      m_cur = 8'hF0; m_op = 3; m_step = 0; m_busy = 256;
`else
      m_cur = 0; m_op = 2; m_step = 0; m_busy = 16;
`endif
   endtask

   task automatic m_accept(input int b);
      int row;
      int col;
      row = m_cur / 16;
      col = m_cur % 16;
      if (b >= 32 && b <= 126) begin
         mm[m_cur] = b;
         if (col < 15) m_cur = m_cur + 1;
         else if (row < 15) m_cur = (row + 1) * 16;
         else m_eos();
      end else if (b == 13) begin
         m_cur = row * 16;
      end else if (b == 10) begin
         if (row < 15) m_cur = (row + 1) * 16;
         else m_eos();
      end else if (b == 8) begin
         if (col > 0) begin
            m_cur = m_cur - 1;
            mm[m_cur] = 32;
         end
      end else if (b == 12) begin
         m_cur = 0; m_op = 1; m_step = 0; m_busy = 256;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mm[i] = -1;
      m_live = 1'b0;
      forever begin
         @(posedge clk or posedge rst);
         m_live = 1'b1;
         if (rst) begin
            m_cur = 0; m_op = 1; m_step = 0; m_busy = 256; m_exp = 0;
         end else if (clk) begin
            m_exp = mm[char_xy];
            if (m_busy > 0) begin
               if (m_op == 3 && m_step < 240) mm[m_step] = mm[m_step + 16];
               else mm[m_step] = 32;
               m_step = m_step + 1;
               m_busy = m_busy - 1;
            end else if (in_valid) begin
               m_accept(int'(in_data));
            end
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge
   always @(negedge clk) begin
      if (m_live) begin
         chk("cursor", cursor_xy, m_cur);
         chk("in_ready", in_ready, (m_busy == 0));
         chk("busy", busy, (m_busy != 0));
         if (m_exp >= 0) chk("char_code", char_code, m_exp);
      end
   end

   int scan;

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!in_ready && cnt < 2000) begin
         char_xy = scan[7:0];
         scan = scan + 7;
         @(posedge clk); #1;
         cnt = cnt + 1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      in_data = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 2000) begin
         @(posedge clk); #1;
         t = t + 1;
      end
      chk("send_wait", (t < 2000), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic read_cell(input logic [7:0] a, input logic [6:0] exp, input string nm);
      char_xy = a;
      @(posedge clk); #1;
      chk(nm, char_code, exp);
   endtask

   int cnt;

   initial begin
      n_chk = 0; n_err = 0; scan = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; char_xy = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_code", char_code, 7'h00);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_cursor", cursor_xy, 8'h00);
      rst = 1'b0;
      wait_ready(cnt);
      chk("rst_sweep_len", cnt, 256);
      read_cell(8'h00, 7'h20, "blank_00");
      read_cell(8'h7F, 7'h20, "blank_7f");
      read_cell(8'hFF, 7'h20, "blank_ff");

      // Back-to-back "AB" with a colliding read of cell 0
      char_xy = 8'h00;
      send(8'h41);
      chk("collide_old", char_code, 7'h20);
      send(8'h42);
      chk("collide_new", char_code, 7'h41);
      chk("ab_cursor", cursor_xy, 8'h02);
      read_cell(8'h01, 7'h42, "cell_01_B");

      // Line wrap
      send(8'h0D);
      for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
      send(8'h5A);
      chk("wrap_cursor", cursor_xy, 8'h11);
      read_cell(8'h10, 7'h5A, "wrap_Z");
      read_cell(8'h0F, 7'h70, "wrap_p");

      // Backspace, BS at column 0, ignored bytes
      send(8'h0D);
      send(8'h58);
      send(8'h59);
      send(8'h08);
      chk("bs_cursor", cursor_xy, 8'h11);
      read_cell(8'h11, 7'h20, "bs_erased");
      read_cell(8'h10, 7'h58, "bs_kept");
      send(8'h0D);
      send(8'h08);
      chk("bs_col0_cursor", cursor_xy, 8'h10);
      send(8'h80);
      send(8'h07);
      chk("ignored_cursor", cursor_xy, 8'h10);
      read_cell(8'h10, 7'h58, "bs_col0_cell");

      // FF with in_valid held high
      in_data = 8'h0C; in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = 8'h51;
      wait_ready(cnt);
      chk("ff_busy_len", cnt, 256);
      chk("ff_cursor", cursor_xy, 8'h00);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ff_q_cursor", cursor_xy, 8'h01);
      read_cell(8'h00, 7'h51, "ff_q_cell");
      read_cell(8'h10, 7'h20, "ff_cleared");

      // Reset in the middle of a sweep restarts it
      send(8'h0C);
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_ready(cnt);
      chk("midrst_len", cnt, 256);
      chk("midrst_cursor", cursor_xy, 8'h00);

      // Fill every cell but the last with its row digit, then LF on row 15
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            if (!(r == 15 && c == 15)) send(8'h30 + 8'(r));
      chk("fill_cursor", cursor_xy, 8'hFF);
      send(8'h0A);
      wait_ready(cnt);
`ifdef CHAR_TERM_SCROLL_EN
      chk("eos_len", cnt, 256);
      chk("eos_cursor", cursor_xy, 8'hF0);
      read_cell(8'h00, 7'h31, "scroll_r0");
      read_cell(8'h0F, 7'h31, "scroll_r0_end");
      read_cell(8'hE0, 7'h3F, "scroll_r14");
      read_cell(8'hEF, 7'h20, "scroll_r14_end");
      read_cell(8'hF0, 7'h20, "scroll_r15");
      read_cell(8'hFF, 7'h20, "scroll_r15_end");
`else
      chk("eos_len", cnt, 16);
      chk("eos_cursor", cursor_xy, 8'h00);
      read_cell(8'h00, 7'h20, "rowclr_r0");
      read_cell(8'h0F, 7'h20, "rowclr_r0_end");
      read_cell(8'h10, 7'h31, "rowclr_r1");
      read_cell(8'h1F, 7'h31, "rowclr_r1_end");
      read_cell(8'hFE, 7'h3F, "rowclr_r15");
      read_cell(8'hFF, 7'h20, "rowclr_last");
`endif
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/char_term_16x16.md
# char_term_16x16

Writable 16x16 character buffer with a terminal-style byte write port. It is the writer-side counterpart of the fixed 16x16 character ROM. A byte stream (ASCII, valid/ready) is placed at a hardware cursor, with CR/LF/BS/FF handling, wrap-around and end-of-screen handling. The read port matches the ROM's: row/column address in, 7-bit char code out one cycle later. The text renderer can therefore use it as a drop-in source.

## Interface
Parameters:
- FILL_CHAR, 7'h20: code written by clear, row-clear and backspace operations.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- char_xy  in  8  read address; [7:4] row, [3:0] column.
- char_code  out  7  cell contents at char_xy, registered.
- cursor_xy  out  8  current cursor; [7:4] row, [3:0] column.
- busy  out  1  multi-cycle operation in progress; equals ~in_ready.

## Operation
- Storage is 256 cells x 7 bits. There is no async reset on the cells; reset triggers a sweep instead.
- FSM states: CLEAR, IDLE, ROW_CLR, and SCROLL (SCROLL only with the macro).
- Reset values:
  - state = CLEAR, sweep address = 0, cursor_xy = 8'h00.
  - char_code = 7'h00, in_ready = 0, busy = 1.
- CLEAR: writes FILL_CHAR to one cell per cycle, addresses 0..255, then goes to IDLE.
- IDLE: in_ready = 1. A byte is accepted on any edge with in_valid && in_ready. One byte per cycle is sustained.
- Byte decode on acceptance:
  - 0x20..0x7E:
    - Write in_data[6:0] at the cursor.
    - If col < 15, col+1.
    - If col == 15, col = 0 and row+1. If row was 15, perform the end-of-screen action.
  - 0x0D (CR): col = 0.
  - 0x0A (LF): col = 0 and row+1. If row == 15, perform the end-of-screen action.
  - 0x08 (BS): if col > 0, col-1 and write FILL_CHAR at the new position. At col 0: no effect.
  - 0x0C (FF): cursor = 0x00, then go to CLEAR (full 256-cell sweep).
  - All other bytes, including >= 0x80: consumed with no effect.
- End-of-screen action without the macro:
  - cursor = 0x00.
  - Go to ROW_CLR, which writes FILL_CHAR to cells 0x00..0x0F, one per cycle, then goes to IDLE.
- in_valid while in_ready = 0: not accepted. The source must hold the byte.

## Timing
- Read port:
  - char_code at edge N+1 reflects the cell addressed by char_xy during cycle N.
  - Reads are never stalled, including during CLEAR, ROW_CLR and SCROLL.
- Write/read collision:
  - A read addressing the cell being written in the same cycle returns the old value.
  - A read in the following cycle returns the new value.
- cursor_xy updates on the acceptance edge.
- After deassertion of rst, in_ready rises after exactly 256 clk edges.
- FF: in_ready is low for 256 cycles starting the cycle after acceptance.
- ROW_CLR: in_ready is low for 16 cycles.
- Reset mid-operation: any state returns asynchronously to CLEAR from address 0. The cursor returns to 0x00.
- Sweep and row-clear addresses wrap at 8/4 bits. The terminal count is the last address, with no overrun.

## Configuration
- CHAR_TERM_SCROLL_EN defined:
  - End-of-screen action enters SCROLL instead.
  - SCROLL copies cell[i+16] to cell[i] for i = 0..239, one cell per cycle (240 cycles).
  - It then goes to ROW_CLR on row 15 (cells 0xF0..0xFF, 16 cycles).
  - cursor = 0xF0. in_ready is low for 256 cycles total.
- CHAR_TERM_SCROLL_EN undefined:
  - Wrap-to-top behaviour as specified in Operation.
  - The SCROLL state and its copy datapath are not synthesized.

## Test plan
- Reset release:
  - in_ready = 0 for 256 cycles, then 1.
  - Reads of 0x00, 0x7F and 0xFF return 7'h20.
  - char_code = 0 during reset.
- Send "AB" back-to-back (two consecutive cycles):
  - cell 0x00 = 0x41, cell 0x01 = 0x42, cursor_xy = 0x02.
  - A same-cycle read of 0x00 during the 'A' write returns 0x20.
- Send 16 printable bytes then 'Z':
  - 'Z' lands at 0x10, cursor = 0x11.
- Send "XY", then BS:
  - cell 0x01 = 0x20, cursor = 0x01.
  - BS at col 0 leaves cursor and cells unchanged.
  - Bytes 0x80 and 0x07 are accepted but nothing is written.
- Fill rows 0..15 with row-index characters, then send LF:
  - Without macro: busy for 16 cycles; cursor 0x00; row 0 all 0x20; row 1 intact.
  - With macro: busy for 256 cycles; row 0 holds the old row-1 content; row 15 all 0x20; cursor 0xF0.
- Send FF with in_valid held high afterwards:
  - No byte is accepted for 256 cycles; all cells read 0x20; cursor 0x00.
  - Asserting rst mid-sweep restarts the 256-cycle sweep.
